iterative_alu: RTL and testbench

ITERATIVE_ALU -- requirements
Module: iterative_alu

---
 rtl/iterative_alu.sv | 158 +++++++++++++++
 tb/tb_iterative_alu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// Purpose: multi-cycle ALU with a bit-serial shifter and {N,Z,C,V} flags, valid/ready on both sides.
// Latency: 1 cycle for non-shift ops and zero-amount shifts, k+1 cycles for a shift by k>0.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_valid && out_ready.
module iterative_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_control,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         flags,
    output logic               illegal_op
);

    localparam logic [3:0] OP_SRL  = 4'b0000;
    localparam logic [3:0] OP_SRA  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               illegal_q, illegal_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;

    logic [WIDTH:0]     add_w, sub_w;
    logic [WIDTH-1:0]   op_res, shifted;
    logic               op_c, op_v, op_ill, op_is_shift;
    logic [SHAMT_W-1:0] shamt;

    // N and Z are derived from the result value alone
    function automatic logic [1:0] nz(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], (r == '0)};
    endfunction

    assign add_w = {1'b0, src_a} + {1'b0, src_b};
    assign sub_w = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt = src_b[SHAMT_W-1:0];

    // Single-cycle ALU evaluated on the incoming operands; shifts only load src_a here
    always_comb begin
        op_res      = '0;
        op_c        = 1'b0;
        op_v        = 1'b0;
        op_ill      = 1'b0;
        op_is_shift = 1'b0;
        case (alu_control)
            OP_SRL, OP_SRA, OP_SLL: begin
                op_res      = src_a;
                op_is_shift = 1'b1;
            end
            OP_AND:  op_res = src_a & src_b;
            OP_OR:   op_res = src_a | src_b;
            OP_XOR:  op_res = src_a ^ src_b;
            OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: op_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_ADD: begin
                op_res = add_w[WIDTH-1:0];
                op_c   = add_w[WIDTH];
                op_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_w[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                op_res = sub_w[WIDTH-1:0];
                op_c   = sub_w[WIDTH];
                op_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_w[WIDTH-1] != src_a[WIDTH-1]);
            end
            default: op_ill = 1'b1;
        endcase
    end

    // One-bit shift step of the held value, direction and fill chosen by the captured opcode
    always_comb begin
        shifted = {result_q[WIDTH-2:0], 1'b0};
        case (op_q)
            OP_SRL:  shifted = {1'b0, result_q[WIDTH-1:1]};
            OP_SRA:  shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            default: shifted = {result_q[WIDTH-2:0], 1'b0};
        endcase
    end

    // Next-state and datapath update for IDLE -> (SHIFT) -> DONE -> IDLE
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d      = alu_control;
                    illegal_d = op_ill;
                    result_d  = op_res;
                    flags_d   = op_ill ? 4'b0100 : {nz(op_res), op_c, op_v};
                    cnt_d     = op_is_shift ? shamt : '0;
                    state_d   = (op_is_shift && shamt != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                result_d = shifted;
                flags_d  = {nz(shifted), 2'b00};
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            op_q      <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign result     = result_q;
    assign flags      = flags_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: directed scenarios plus randomized ops against a reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Backpressure is exercised by holding out_ready low for a while after each result.
module tb_iterative_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] src_a, src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        illegal_op;

    int vectors = 0;
    int errors  = 0;

    iterative_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on the operands, plus the expected latency
    function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic [3:0] f,
                                      output logic ill, output int lat);
        logic [32:0] wide;
        logic c, v;
        int   sh;
        sh  = int'(b[4:0]);
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        r   = 32'd0;
        lat = 1;
        case (op)
            4'd0: r = a >> sh;
            4'd1: r = $signed(a) >>> sh;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = (a < b) ? 32'd1 : 32'd0;
            4'd7: r = a << sh;
            4'd8: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[31:0]; c = wide[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd9: begin
                wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = wide[31:0]; c = wide[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: ill = 1'b1;
        endcase
        if ((op == 4'd0 || op == 4'd1 || op == 4'd7) && sh > 0) lat = sh + 1;
        f = ill ? 4'b0100 : {r[31], (r == 32'd0), c, v};
    endfunction

    // Issue one op, scramble inputs while busy, check latency/outputs, hold, then handshake
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic [3:0]  ef;
        logic        ei;
        int          el;
        int          lat;
        ref_model(op, a, b, er, ef, ei, el);
        @(negedge clk);
        alu_control = op; src_a = a; src_b = b; in_valid = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_idle: got %b want 1", in_ready); end
        @(negedge clk);
        alu_control = 4'($urandom); src_a = $urandom; src_b = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat <= 40) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== el) begin errors++; $display("FAIL latency op=%0d: got %0d want %0d", op, lat, el); end
        vectors++;
        if (result !== er) begin errors++; $display("FAIL result op=%0d a=%h b=%h: got %h want %h", op, a, b, result, er); end
        vectors++;
        if (flags !== ef) begin errors++; $display("FAIL flags op=%0d a=%h b=%h: got %b want %b", op, a, b, flags, ef); end
        vectors++;
        if (illegal_op !== ei) begin errors++; $display("FAIL illegal_op op=%0d: got %b want %b", op, illegal_op, ei); end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er || flags !== ef || illegal_op !== ei) begin
                errors++;
                $display("FAIL hold op=%0d cyc=%0d: got v=%b rdy=%b r=%h f=%b i=%b want v=1 rdy=0 r=%h f=%b i=%b",
                         op, i, out_valid, in_ready, result, flags, illegal_op, er, ef, ei);
            end
        end
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_handshake: got %b want 0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        in_valid = 1'b1; alu_control = 4'd8; src_a = 32'd1; src_b = 32'd1; out_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0; reset = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 || flags !== 4'd0 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b rdy=%b r=%h f=%b i=%b want 0 1 0 0 0",
                     out_valid, in_ready, result, flags, illegal_op);
        end
    endtask

    task automatic test_directed;
        run_op(4'd8, 32'h7FFFFFFF, 32'd1, 0);
        run_op(4'd9, 32'd5, 32'd5, 1);
        run_op(4'd9, 32'd0, 32'd1, 0);
        run_op(4'd1, 32'h80000000, 32'd31, 0);
        run_op(4'd7, 32'd1, 32'd0, 0);
        run_op(4'd5, 32'hFFFFFFFF, 32'd1, 0);
        run_op(4'd6, 32'hFFFFFFFF, 32'd1, 0);
        run_op(4'd0, 32'h80000000, 32'd1, 0);
        run_op(4'd7, 32'hFFFFFFFF, 32'd31, 0);
    endtask

    task automatic test_illegal_stall;
        run_op(4'b1100, $urandom, $urandom, 10);
        run_op(4'b1111, $urandom, $urandom, 2);
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        alu_control = 4'd0; src_a = 32'hDEADBEEF; src_b = 32'd20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1 || flags !== 4'd0) begin
            errors++;
            $display("FAIL reset_abort: got v=%b r=%h rdy=%b f=%b want 0 0 1 0", out_valid, result, in_ready, flags);
        end
        run_op(4'd8, 32'd2, 32'd3, 0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 0) a = {a[31], 31'h7FFFFFFF};
            if (i % 5 == 0) b = a;
            run_op(op, a, b, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_control = 4'd0; src_a = 32'd0; src_b = 32'd0;
        test_reset;
        test_directed;
        test_illegal_stall;
        test_reset_abort;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
